// File: rtl/cfu_cmd_issuer.sv
// cfu_cmd_issuer: queues requester commands, issues them one at a time on the
// CFU cmd handshake and collects (or discards) the CFU responses into a result FIFO.
module cfu_cmd_issuer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_function_id,
    input  logic [31:0] req_inputs_0,
    input  logic [31:0] req_inputs_1,
    input  logic        req_keep,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [9:0]  cmd_payload_function_id,
    output logic [31:0] cmd_payload_inputs_0,
    output logic [31:0] cmd_payload_inputs_1,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_payload_outputs_0,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        timeout_err,
    input  logic        clr_err
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int CMD_W = 1 + 10 + 32 + 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Command FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
    logic [CAW:0]     cmd_wr_ptr_reg;
    logic [CAW:0]     cmd_rd_ptr_reg;
    logic             cmd_full;
    logic             cmd_empty;
    logic             cmd_push;
    logic             cmd_pop;
    logic [CMD_W-1:0] cmd_head;

    // Result FIFO storage and pointers
    logic [31:0]      res_mem [RSP_DEPTH];
    logic [RAW:0]     res_wr_ptr_reg;
    logic [RAW:0]     res_rd_ptr_reg;
    logic             res_full;
    logic             res_empty;
    logic             res_push;
    logic             res_pop;

    // FSM, payload registers and timeout tracking
    logic [1:0]       state_reg;
    logic [9:0]       fid_reg;
    logic [31:0]      in0_reg;
    logic [31:0]      in1_reg;
    logic             keep_reg;
    logic [TW-1:0]    wait_cnt_reg;
    logic             timeout_err_reg;
    logic             cmd_hs;
    logic             rsp_hs;
    logic             timeout_set;

    assign cmd_full  = (cmd_wr_ptr_reg[CAW] != cmd_rd_ptr_reg[CAW]) &&
                       (cmd_wr_ptr_reg[CAW-1:0] == cmd_rd_ptr_reg[CAW-1:0]);
    assign cmd_empty = (cmd_wr_ptr_reg == cmd_rd_ptr_reg);
    assign res_full  = (res_wr_ptr_reg[RAW] != res_rd_ptr_reg[RAW]) &&
                       (res_wr_ptr_reg[RAW-1:0] == res_rd_ptr_reg[RAW-1:0]);
    assign res_empty = (res_wr_ptr_reg == res_rd_ptr_reg);

    // req_ready is forced low while reset is held so every output reads 0 in reset
    assign req_ready = !reset && !cmd_full;
    assign cmd_push  = req_valid && req_ready;
    assign cmd_pop   = (state_reg == ST_IDLE) && !cmd_empty;
    assign cmd_head  = cmd_mem[cmd_rd_ptr_reg[CAW-1:0]];

    assign cmd_valid               = (state_reg == ST_ISSUE);
    assign cmd_payload_function_id = fid_reg;
    assign cmd_payload_inputs_0    = in0_reg;
    assign cmd_payload_inputs_1    = in1_reg;
    assign cmd_hs                  = cmd_valid && cmd_ready;

    // Dropped responses never need result space, so they are always accepted
    assign rsp_ready = (state_reg == ST_WAIT) && (!keep_reg || !res_full);
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign res_push  = rsp_hs && keep_reg;

    assign res_valid = !res_empty;
    assign res_pop   = res_valid && res_ready;
    assign res_data  = res_empty ? 32'd0 : res_mem[res_rd_ptr_reg[RAW-1:0]];

    assign busy        = (state_reg != ST_IDLE) || !cmd_empty;
    assign timeout_err = timeout_err_reg;

    // Fires once, on the WAIT cycle that brings the counter up to TIMEOUT
    assign timeout_set = (state_reg == ST_WAIT) && !rsp_hs &&
                         (wait_cnt_reg == TW'(TIMEOUT - 1));

    // Command FIFO write port (storage is not reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr_reg[CAW-1:0]] <= {req_keep, req_function_id, req_inputs_0, req_inputs_1};
        end
    end

    // Command FIFO pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_wr_ptr_reg <= '0;
            cmd_rd_ptr_reg <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wr_ptr_reg <= cmd_wr_ptr_reg + 1'b1;
            end
            if (cmd_pop) begin
                cmd_rd_ptr_reg <= cmd_rd_ptr_reg + 1'b1;
            end
        end
    end

    // Result FIFO write port
    always_ff @(posedge clk) begin
        if (res_push) begin
            res_mem[res_wr_ptr_reg[RAW-1:0]] <= rsp_payload_outputs_0;
        end
    end

    // Result FIFO pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_wr_ptr_reg <= '0;
            res_rd_ptr_reg <= '0;
        end else begin
            if (res_push) begin
                res_wr_ptr_reg <= res_wr_ptr_reg + 1'b1;
            end
            if (res_pop) begin
                res_rd_ptr_reg <= res_rd_ptr_reg + 1'b1;
            end
        end
    end

    // Issue FSM: IDLE pops into the payload regs, ISSUE holds cmd_valid, WAIT collects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            fid_reg   <= '0;
            in0_reg   <= '0;
            in1_reg   <= '0;
            keep_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!cmd_empty) begin
                        {keep_reg, fid_reg, in0_reg, in1_reg} <= cmd_head;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rsp_hs) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Saturating response-wait counter, restarted on every entry to WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (cmd_hs) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == ST_WAIT) && !rsp_hs && (wait_cnt_reg != TW'(TIMEOUT))) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    // Sticky timeout flag; a set in the same cycle as clr_err takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err_reg <= 1'b0;
        end else if (timeout_set) begin
            timeout_err_reg <= 1'b1;
        end else if (clr_err) begin
            timeout_err_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Testbench for cfu_cmd_issuer: directed requests, a simple CFU responder model,
// and a scoreboard monitor that checks every cmd and result handshake in order.
module tb_cfu_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_function_id = '0;
    logic [31:0] req_inputs_0 = '0;
    logic [31:0] req_inputs_1 = '0;
    logic        req_keep = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0 = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        busy;
    logic        timeout_err;
    logic        clr_err = 1'b0;

    always #5 clk = ~clk;

    cfu_cmd_issuer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_function_id(req_function_id), .req_inputs_0(req_inputs_0),
        .req_inputs_1(req_inputs_1), .req_keep(req_keep),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0),
        .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(rsp_payload_outputs_0),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    int checks = 0;
    int errors = 0;
    int cmd_hs_cnt = 0;
    int rsp_hs_cnt = 0;
    int res_seen = 0;

    logic [73:0] exp_cmd_q[$];
    logic [31:0] exp_res_q[$];
    logic [31:0] cfu_rsp_q[$];

    // CFU model controls
    logic        cfu_ready_en = 1'b1;
    logic        cfu_rsp_en = 1'b1;
    int          cfu_delay = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // CFU responder: accepts a command, answers cfu_delay cycles later
    initial begin : cfu_model
        logic        pending;
        logic        rsp_fire;
        int          countdown;
        logic [31:0] cur_data;
        pending = 1'b0; rsp_fire = 1'b0; countdown = 0; cur_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending = 1'b0; rsp_fire = 1'b0;
                rsp_valid = 1'b0; cmd_ready = 1'b0;
            end else begin
                if (rsp_fire) begin
                    rsp_fire = 1'b0; pending = 1'b0; rsp_valid = 1'b0;
                end
                if (pending && countdown > 0) countdown--;
                if (pending && countdown == 0 && cfu_rsp_en) begin
                    rsp_valid = 1'b1;
                    rsp_payload_outputs_0 = cur_data;
                end
                cmd_ready = cfu_ready_en && !pending;
                #1;
                if (cmd_valid && cmd_ready) begin
                    pending = 1'b1;
                    countdown = cfu_delay;
                    cur_data = (cfu_rsp_q.size() > 0) ? cfu_rsp_q.pop_front() : 32'd0;
                end
                if (rsp_valid && rsp_ready) rsp_fire = 1'b1;
            end
        end
    end

    // Scoreboard monitor: handshakes that will complete at the coming posedge
    initial begin : monitor
        logic [73:0] ec;
        logic [31:0] er;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (cmd_valid && cmd_ready) begin
                    cmd_hs_cnt++;
                    checks++;
                    if (exp_cmd_q.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_unexpected actual_fid=0x%03h required=none", cmd_payload_function_id);
                    end else begin
                        ec = exp_cmd_q.pop_front();
                        $display("cmd fid=0x%03h in0=0x%08h in1=0x%08h", cmd_payload_function_id,
                                 cmd_payload_inputs_0, cmd_payload_inputs_1);
                        if ({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !== ec) begin
                            errors++;
                            $display("FAIL cmd_payload actual=0x%019h required=0x%019h",
                                     {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}, ec);
                        end
                    end
                end
                if (rsp_valid && rsp_ready) rsp_hs_cnt++;
                if (res_valid) res_seen++;
                if (res_valid && res_ready) begin
                    checks++;
                    if (exp_res_q.size() == 0) begin
                        errors++;
                        $display("FAIL res_unexpected actual=0x%08h required=none", res_data);
                    end else begin
                        er = exp_res_q.pop_front();
                        $display("res data=0x%08h", res_data);
                        if (res_data !== er) begin
                            errors++;
                            $display("FAIL res_data actual=0x%08h required=0x%08h", res_data, er);
                        end
                    end
                end
            end
        end
    end

    // Present one request and hold it until accepted; returns at the following negedge
    task automatic push_req(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic k, input logic [31:0] rsp);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_function_id = f; req_inputs_0 = a; req_inputs_1 = b; req_keep = k;
        #1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout actual=req_ready_low required=req_ready_high");
            req_valid = 1'b0;
            return;
        end
        exp_cmd_q.push_back({f, a, b});
        cfu_rsp_q.push_back(rsp);
        if (k) exp_res_q.push_back(rsp);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk); #2;
            if (!busy && !res_valid && exp_res_q.size() == 0 && exp_cmd_q.size() == 0) break;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s actual=still_busy required=idle", name);
        end
    endtask

    task automatic wait_cmd_hs(input int target, input string name);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk); #2;
            if (cmd_hs_cnt >= target) break;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, cmd_hs_cnt, target);
        end
    endtask

    initial begin : watchdog
        #300000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        int base;
        int acc;
        int seen0;
        int n;

        // Reset state
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_rsp_ready", rsp_ready, 0);
        chk("rst_timeout_err", timeout_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("rel_req_ready", req_ready, 1);

        // Single kept command, 3-cycle CFU latency
        cfu_delay = 3;
        push_req(10'h008, 32'h01020304, 32'd5, 1'b1, 32'h00001234);
        chk("t1_cmd_valid_early", cmd_valid, 0);
        @(posedge clk); #1;
        chk("t1_cmd_valid_n1", cmd_valid, 1);
        chk("t1_fid", cmd_payload_function_id, 32'h008);
        chk("t1_busy", busy, 1);
        wait_idle("t1_idle");
        chk("t1_busy_after", busy, 0);

        // Dropped response
        cfu_delay = 2;
        base = rsp_hs_cnt;
        seen0 = res_seen;
        push_req(10'h010, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF);
        wait_idle("t2_idle");
        repeat (3) @(negedge clk);
        chk("t2_rsp_hs", rsp_hs_cnt, base + 1);
        chk("t2_res_seen", res_seen, seen0);
        chk("t2_busy", busy, 0);

        // Result backpressure with five kept commands
        cfu_delay = 1;
        @(negedge clk);
        res_ready = 1'b0;
        base = cmd_hs_cnt;
        for (int i = 1; i <= 5; i++) begin
            push_req(10'h030 + 10'(i), 32'(i), ~32'(i), 1'b1, 32'(i));
        end
        wait_cmd_hs(base + 5, "t3_fifth_issue");
        repeat (3) @(negedge clk);
        #2;
        chk("t3_rsp_ready_low", rsp_ready, 0);
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_busy", busy, 1);
        chk("t3_res_head", res_data, 32'd1);
        @(negedge clk);
        res_ready = 1'b1;
        wait_idle("t3_drain");

        // Command FIFO full with the CFU refusing commands
        @(negedge clk);
        cfu_ready_en = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_function_id = 10'h020 + 10'(acc);
            req_inputs_0 = 32'(acc);
            req_inputs_1 = 32'h0;
            req_keep = 1'b1;
            #1;
            if (req_ready) begin
                exp_cmd_q.push_back({req_function_id, req_inputs_0, req_inputs_1});
                cfu_rsp_q.push_back(32'h100 + 32'(acc));
                exp_res_q.push_back(32'h100 + 32'(acc));
                acc++;
            end
        end
        chk("t4_accepted", acc, 5);
        chk("t4_req_ready_low", req_ready, 0);
        @(negedge clk);
        req_valid = 1'b0;
        cfu_ready_en = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk); #2;
            if (req_ready) break;
        end
        chk("t4_req_ready_rise", req_ready, 1);
        wait_idle("t4_drain");

        // Response timeout, late response, clear
        chk("t5_err_init", timeout_err, 0);
        cfu_rsp_en = 1'b0;
        base = cmd_hs_cnt;
        push_req(10'h040, 32'h0, 32'h0, 1'b1, 32'h00000055);
        wait_cmd_hs(base + 1, "t5_issue");
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1;
        chk("t5_err_before", timeout_err, 0);
        @(posedge clk); #1;
        chk("t5_err_set", timeout_err, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_err_sticky", timeout_err, 1);
        @(negedge clk);
        cfu_rsp_en = 1'b1;
        wait_idle("t5_late_rsp");
        chk("t5_err_after_rsp", timeout_err, 1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        chk("t5_err_cleared", timeout_err, 0);

        // Asynchronous reset while waiting on a response
        @(negedge clk);
        res_ready = 1'b0;
        cfu_delay = 1;
        base = cmd_hs_cnt;
        push_req(10'h050, 32'hA, 32'h0, 1'b1, 32'h0000000A);
        for (n = 0; n < 50; n++) begin
            @(negedge clk); #2;
            if (res_valid) break;
        end
        @(negedge clk);
        cfu_rsp_en = 1'b0;
        push_req(10'h051, 32'hB, 32'h0, 1'b1, 32'h0000000B);
        push_req(10'h052, 32'hC, 32'h0, 1'b1, 32'h0000000C);
        wait_cmd_hs(base + 2, "t6_issue");
        repeat (20) @(posedge clk);
        #1;
        chk("t6_err_pre", timeout_err, 1);
        chk("t6_res_valid_pre", res_valid, 1);
        chk("t6_rsp_ready_pre", rsp_ready, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_cmd_valid", cmd_valid, 0);
        chk("t6_rsp_ready", rsp_ready, 0);
        chk("t6_res_valid", res_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_timeout_err", timeout_err, 0);
        chk("t6_req_ready_rst", req_ready, 0);
        @(negedge clk);
        exp_cmd_q.delete();
        exp_res_q.delete();
        cfu_rsp_q.delete();
        cfu_rsp_en = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_req_ready_rel", req_ready, 1);
        chk("t6_busy_rel", busy, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("t6_no_stale_cmd", cmd_valid, 0);
        push_req(10'h060, 32'h6, 32'h7, 1'b1, 32'h00000066);
        wait_idle("t6_post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_cmd_issuer.md
Name: cfu_cmd_issuer

Overview:
Initiator-side driver for the CFU custom-instruction port: queues commands from a local requester, issues them one at a time on the CFU cmd handshake and collects responses. It sits between a DMA/sequencer front end and the CFU, and lets bulk operations run without CPU involvement. Examples are filter-table loads, accumulator resets and SIMD MAC streams. Per-command flag selects whether the CFU response is forwarded or discarded (e.g. filter-store writes).

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 4, result FIFO entries (power of 2, >=2)
TIMEOUT, 1023, cycles in WAIT before timeout_err sets (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  requester command valid
req_ready  out  1  command FIFO not full
req_function_id  in  10  function id to issue
req_inputs_0  in  32  operand 0
req_inputs_1  in  32  operand 1
req_keep  in  1  1: forward response to result FIFO; 0: drop it
cmd_valid  out  1  to CFU
cmd_ready  in  1  from CFU
cmd_payload_function_id  out  10  to CFU
cmd_payload_inputs_0  out  32  to CFU
cmd_payload_inputs_1  out  32  to CFU
rsp_valid  in  1  from CFU
rsp_ready  out  1  to CFU
rsp_payload_outputs_0  in  32  from CFU
res_valid  out  1  result FIFO non-empty
res_ready  in  1  result consumer ready
res_data  out  32  head of result FIFO
busy  out  1  state!=IDLE or command FIFO non-empty
timeout_err  out  1  sticky response-timeout flag
clr_err  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (async, active-high): both FIFOs empty, state IDLE, payload regs 0, timeout counter 0. All outputs 0 while reset is asserted, except req_ready, which is 1 after release. Reset mid-operation abandons the in-flight command with no response tracking.
- Command FIFO: push on req_valid&&req_ready; req_ready=!full, no bypass. Push and pop in the same cycle are legal when not full. Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, ISSUE, WAIT. At most one command outstanding.
- IDLE: if command FIFO non-empty, pop at clock edge, load function_id/inputs/keep into payload regs, go to ISSUE.
- ISSUE: cmd_valid=1, payload driven from regs and held stable until cmd_valid&&cmd_ready. cmd_valid is never withdrawn before the handshake. On handshake go to WAIT.
- WAIT: rsp_ready = !keep || !result_full. On rsp_valid&&rsp_ready, push rsp_payload_outputs_0 if keep and go to IDLE.
- Latency: req handshake at edge N gives cmd_valid high after edge N+1. Response handshake at edge M gives res_valid high after M. The next queued command has cmd_valid high after M+1, so there is one bubble cycle between commands.
- Result FIFO: res_valid=!empty; pop on res_valid&&res_ready. Simultaneous push and pop while full is not possible, because rsp_ready is low when the FIFO is full. Order matches issue order.
- Timeout: counter clears on entry to WAIT and increments each WAIT cycle without a response handshake. When the count reaches TIMEOUT, timeout_err sets. The FSM keeps waiting and a late response is accepted normally. If clr_err and the set condition occur in the same cycle, set wins. The counter saturates.
- busy is registered-state derived and does not depend on res FIFO occupancy.

Test Plan:
- Single kept command: req fid=0x008, in0=0x01020304, in1=5, keep=1; CFU model asserts cmd_ready immediately and returns 0x00001234 three cycles later. Required: cmd_valid high exactly one cycle after the req edge, payload matches the request, one res_data=0x00001234, busy drops after the response.
- Dropped response: keep=0, fid=0x010; CFU returns 0xDEADBEEF. Required: rsp_ready high in WAIT, res_valid never asserts, FSM returns to IDLE.
- Result backpressure: five keep=1 commands with responses 1..5, res_ready=0, RSP_DEPTH=4. Required: rsp_ready low during the fifth WAIT. After res_ready=1, res_data sequence is 1,2,3,4,5.
- Command FIFO full: cmd_ready held 0, req_valid held 1. Required: exactly CMD_DEPTH+1=5 requests accepted (one in the payload regs), then req_ready=0 until cmd_ready rises.
- Timeout: TIMEOUT=16, CFU never asserts rsp_valid. Required: timeout_err rises after the 16th WAIT cycle and stays high. A late response 0x55 is delivered to res_data. Pulsing clr_err clears the flag.
- Async reset mid-WAIT: reset asserted between edges. Required: cmd_valid, rsp_ready, res_valid, busy and timeout_err go to 0 immediately. After release, queued commands are gone and req_ready=1.
